load_store_unit: RTL
====================

// Module: load_store_unit
// PURPOSE
// Memory-access stage directly downstream of the ALU in the unicycle RISC-V core.
// Takes the ALU's effective address (alu_result), the store operand and opcode/func3.
// Runs a req/gnt/rvalid transaction on the data-memory bus and returns aligned,
// sign/zero-extended load data for writeback. Holds the PC via `stall` until the access completes.
// PARAMETERS
// WIDTH           32  datapath / address width
// TIMEOUT_CYCLES  16  max cycles in WAIT before a bus-timeout exception (>=1)
// PORTS
// clk          in   1      core clock; all state updates on rising edge
// rst          in   1      synchronous, active-high reset
// valid_i      in   1      current instruction is valid
// opcode       in   7      instruction opcode
// func3        in   3      access size / sign
// addr         in   WIDTH  effective address (ALU alu_result)
// store_data   in   WIDTH  rs2 register value for stores
// mem_req      out  1      bus request (registered)
// mem_we       out  1      1 = write
// mem_addr     out  WIDTH  word-aligned address ({addr[WIDTH-1:2],2'b00})
// mem_wdata    out  32     lane-replicated store data
// mem_be       out  4      byte enables
// mem_gnt      in   1      request accepted this cycle
// mem_rvalid   in   1      read data valid
// mem_rdata    in   32     read data word
// stall        out  1      hold PC/instruction this cycle
// wb_valid     out  1      one-cycle pulse: load_data valid for register writeback
// load_data    out  WIDTH  extended load result
// exc_o        out  1      one-cycle exception pulse
// exc_cause    out  2      01 misaligned, 10 illegal func3, 11 bus timeout
// BEHAVIOUR
// - Mem op = valid_i && opcode in {0000011 load, 0100011 store}. All other ops: stall=0, no bus activity.
// - FSM: IDLE -> REQ -> (load: WAIT) -> DONE -> IDLE.
//   - IDLE: on mem op, latch addr/func3/store_data/we; go to REQ.
//   - REQ: mem_req=1, held until mem_gnt; then store->DONE, load->WAIT.
//   - WAIT: on mem_rvalid capture extended data -> DONE. Timeout counter reaching TIMEOUT_CYCLES -> DONE with exc cause 11, load_data=0.
//   - DONE: stall=0, wb_valid=1 (loads without exception only); unconditional return to IDLE.
// - stall = mem op && state!=DONE (combinational; includes the IDLE detection cycle).
// - Min latency: store 3 cycles (IDLE,REQ,DONE); load 4 cycles (IDLE,REQ,WAIT,DONE).
// - Sizes: func3 000 B, 001 H, 010 W, 100 BU, 101 HU (loads); 000/001/010 for stores.
//   - Other func3: exc cause 10, no bus access.
// - Misaligned: H with addr[0]!=0, W with addr[1:0]!=0.
//   - Exception cause 01 with no bus access: IDLE->DONE directly, so stall is 1 for the detection cycle only.
// - Store lanes:
//   - SB: be=4'b0001<<addr[1:0], wdata={4{byte}}
//   - SH: be=4'b0011<<addr[1:0], wdata={2{half}}
//   - SW: be=4'b1111, wdata=store_data
// - Load extraction: byte/half selected by addr[1:0]; sign-extend for B/H, zero-extend for BU/HU.
// - mem_rvalid outside WAIT and mem_gnt outside REQ are ignored.
// - Once REQ is entered the access completes even if valid_i drops.
// - Reset: next edge -> IDLE.
//   - mem_req, mem_we, mem_be, wb_valid, exc_o, exc_cause = 0; load_data, mem_addr, mem_wdata = 0; timeout counter = 0.
//   - A reset mid-transaction abandons it; later rvalid is ignored.
// - Back-to-back mem ops: the next op is detected in IDLE the cycle after DONE.
// STRUCTURE
// - lsu_pkg: opcode constants (MEM_RD_OP, MEM_WR_OP), func3 size encodings, lsu_state_t enum, exc-cause enum.
// - Sub-module lsu_align (combinational): byte-enable/wdata replication, misalign/illegal check, load extract+extend.
// TESTING
// 1 SW addr=0x100 data=0xDEADBEEF, gnt at 1st REQ cycle -> be=1111, wdata=0xDEADBEEF, stall 2 cycles, done in 3.
// 2 LB addr=0x103, rdata=0x80xxxxxx, rvalid after 2 WAIT cycles -> load_data=0xFFFFFF80, wb_valid 1 pulse.
// 3 LHU addr=0x102, rdata=0xBEEF1234 -> load_data=0x0000BEEF; LH addr=0x101 -> exc cause 01, mem_req never 1.
// 4 SB addr=0x22 data=0x000000AB -> be=0100, wdata=0xABABABAB; func3=011 load -> exc cause 10, no request.
// 5 Load, rvalid never arrives -> after TIMEOUT_CYCLES exc cause 11, load_data=0, stall falls.
// 6 rst asserted in WAIT -> IDLE next cycle, mem_req=0; a late rvalid produces no wb_valid.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: opcodes, access sizes, FSM states, exception causes.
package lsu_pkg;

    localparam logic [6:0] MEM_RD_OP = 7'b0000011;
    localparam logic [6:0] MEM_WR_OP = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10,
        ST_DONE = 2'b11
    } lsu_state_t;

    typedef enum logic [1:0] {
        EXC_NONE     = 2'b00,
        EXC_MISALIGN = 2'b01,
        EXC_ILLEGAL  = 2'b10,
        EXC_TIMEOUT  = 2'b11
    } exc_cause_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte enables / replication, access legality, load extract + extend.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       req_func3,
    input  logic [1:0]       req_addr_lo,
    input  logic             req_store,
    input  logic [31:0]      store_data,
    output logic [3:0]       be,
    output logic [31:0]      wdata,
    output logic             illegal,
    output logic             misaligned,
    input  logic [2:0]       rsp_func3,
    input  logic [1:0]       rsp_addr_lo,
    input  logic [31:0]      rdata,
    output logic [WIDTH-1:0] load_ext
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        be         = 4'b0000;
        wdata      = store_data;
        illegal    = 1'b0;
        misaligned = 1'b0;
        case (req_func3)
            F3_B: begin
                be    = 4'b0001 << req_addr_lo;
                wdata = {4{store_data[7:0]}};
            end
            F3_H: begin
                be         = 4'b0011 << req_addr_lo;
                wdata      = {2{store_data[15:0]}};
                misaligned = req_addr_lo[0];
            end
            F3_W: begin
                be         = 4'b1111;
                misaligned = |req_addr_lo;
            end
            // Unsigned sizes only exist for loads
            F3_BU: begin
                be      = 4'b0001 << req_addr_lo;
                illegal = req_store;
            end
            F3_HU: begin
                be         = 4'b0011 << req_addr_lo;
                illegal    = req_store;
                misaligned = req_addr_lo[0];
            end
            default: illegal = 1'b1;
        endcase
    end

    always_comb begin
        byte_sel = rdata[{rsp_addr_lo, 3'b000} +: 8];
        half_sel = rsp_addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (rsp_func3)
            F3_B:    load_ext = {{(WIDTH-8){byte_sel[7]}}, byte_sel};
            F3_H:    load_ext = {{(WIDTH-16){half_sel[15]}}, half_sel};
            F3_BU:   load_ext = {{(WIDTH-8){1'b0}}, byte_sel};
            F3_HU:   load_ext = {{(WIDTH-16){1'b0}}, half_sel};
            default: load_ext = WIDTH'(rdata);
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: runs one req/gnt/rvalid bus transaction per load/store and stalls the PC meanwhile.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    input  logic [6:0]       opcode,
    input  logic [2:0]       func3,
    input  logic [WIDTH-1:0] addr,
    input  logic [WIDTH-1:0] store_data,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_be,
    input  logic             mem_gnt,
    input  logic             mem_rvalid,
    input  logic [31:0]      mem_rdata,
    output logic             stall,
    output logic             wb_valid,
    output logic [WIDTH-1:0] load_data,
    output logic             exc_o,
    output logic [1:0]       exc_cause
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_t       state;
    logic [CNT_W-1:0] tmo_cnt;
    logic [2:0]       lat_func3;
    logic [1:0]       lat_addr_lo;

    logic             is_store;
    logic             mem_op;
    logic [3:0]       al_be;
    logic [31:0]      al_wdata;
    logic             al_illegal;
    logic             al_misaligned;
    logic [WIDTH-1:0] al_load;

    assign is_store = (opcode == MEM_WR_OP);
    assign mem_op   = valid_i && ((opcode == MEM_RD_OP) || is_store);

    // An access already on the bus keeps stalling even if valid_i drops
    assign stall = (state == ST_IDLE) ? mem_op : ((state == ST_REQ) || (state == ST_WAIT));

    lsu_align #(.WIDTH(WIDTH)) u_align (
        .req_func3   (func3),
        .req_addr_lo (addr[1:0]),
        .req_store   (is_store),
        .store_data  (store_data[31:0]),
        .be          (al_be),
        .wdata       (al_wdata),
        .illegal     (al_illegal),
        .misaligned  (al_misaligned),
        .rsp_func3   (lat_func3),
        .rsp_addr_lo (lat_addr_lo),
        .rdata       (mem_rdata),
        .load_ext    (al_load)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            tmo_cnt     <= '0;
            lat_func3   <= 3'b000;
            lat_addr_lo <= 2'b00;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_be      <= 4'b0000;
            wb_valid    <= 1'b0;
            load_data   <= '0;
            exc_o       <= 1'b0;
            exc_cause   <= EXC_NONE;
        end else begin
            wb_valid  <= 1'b0;
            exc_o     <= 1'b0;
            exc_cause <= EXC_NONE;
            case (state)
                ST_IDLE: begin
                    if (mem_op) begin
                        if (al_illegal) begin
                            state     <= ST_DONE;
                            exc_o     <= 1'b1;
                            exc_cause <= EXC_ILLEGAL;
                            load_data <= '0;
                        end else if (al_misaligned) begin
                            state     <= ST_DONE;
                            exc_o     <= 1'b1;
                            exc_cause <= EXC_MISALIGN;
                            load_data <= '0;
                        end else begin
                            state       <= ST_REQ;
                            mem_req     <= 1'b1;
                            mem_we      <= is_store;
                            mem_addr    <= {addr[WIDTH-1:2], 2'b00};
                            mem_wdata   <= al_wdata;
                            mem_be      <= al_be;
                            lat_func3   <= func3;
                            lat_addr_lo <= addr[1:0];
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        tmo_cnt <= '0;
                        state   <= mem_we ? ST_DONE : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mem_rvalid) begin
                        load_data <= al_load;
                        wb_valid  <= 1'b1;
                        state     <= ST_DONE;
                    end else if (tmo_cnt == CNT_LAST) begin
                        load_data <= '0;
                        exc_o     <= 1'b1;
                        exc_cause <= EXC_TIMEOUT;
                        state     <= ST_DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
